lsu_mem_initiator: RTL and testbench

- Load/store initiator between the MEM pipeline stage and the byte-addressed, little-endian data memory port.
- That port has a 3-bit function code, 32-bit addr/write_data and a 32-bit read_data. Reads are combinational; writes commit on posedge clk.
- Accepts one load/store request per handshake and drives the memory port from registered state.
- Splits misaligned halfword/word accesses into per-byte beats, then returns assembled, sign/zero-extended load data with a one-cycle response pulse.

---
 rtl/lsu_mem_initiator_pkg.sv | 27 ++
 rtl/lsu_load_extend.sv | 23 ++
 rtl/lsu_mem_defines.sv | 14 +
 rtl/lsu_mem_initiator.sv | 167 ++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_initiator_pkg.sv
// Local types and decode helpers for the load/store initiator.
`ifndef LSU_MEM_DEFINES_SV
`include "lsu_mem_defines.sv"
`endif

package lsu_mem_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } lsu_state_e;

    // Access size in bytes for a function code (1, 2 or 4).
    function automatic logic [2:0] op_size(input logic [2:0] op);
        case (op)
            `MEM_LH, `MEM_LHU, `MEM_SH: op_size = 3'd2;
            `MEM_LW, `MEM_SW:           op_size = 3'd4;
            default:                    op_size = 3'd1;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [2:0] op);
        op_is_store = (op == `MEM_SB) || (op == `MEM_SH) || (op == `MEM_SW);
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of assembled little-endian load bytes; stores yield 0.
module lsu_load_extend
    import lsu_mem_initiator_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] data_i,
    output logic [31:0] result_o
);

    // Select extension by function code.
    always_comb begin
        result_o = '0;
        case (op_i)
            `MEM_LB:  result_o = {{24{data_i[7]}}, data_i[7:0]};
            `MEM_LBU: result_o = {24'h0, data_i[7:0]};
            `MEM_LH:  result_o = {{16{data_i[15]}}, data_i[15:0]};
            `MEM_LHU: result_o = {16'h0, data_i[15:0]};
            `MEM_LW:  result_o = data_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_defines.sv
// Shared data-memory function codes. The data memory uses the same header.
`ifndef LSU_MEM_DEFINES_SV
`define LSU_MEM_DEFINES_SV

`define MEM_LB  3'd0
`define MEM_LH  3'd1
`define MEM_LW  3'd2
`define MEM_LBU 3'd3
`define MEM_LHU 3'd4
`define MEM_SB  3'd5
`define MEM_SH  3'd6
`define MEM_SW  3'd7

`endif

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one request per handshake, misaligned accesses split
// into byte beats, one-cycle response pulse with extended load data.
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high; req_ready_o is high only in IDLE, so the
// requester holds req_valid_i and its fields stable until that edge.
module lsu_mem_initiator
    import lsu_mem_initiator_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [2:0]  mem_fn_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output lsu_state_e  state_o
);

    lsu_state_e  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] asm_q, asm_d;
    logic [2:0]  beats_q, beats_d;
    logic [1:0]  beat_q, beat_d;
    logic        mis_q, mis_d;
    logic        err_q, err_d;

    logic [2:0]  req_size;
    logic        req_aligned;
    logic        last_beat;
    logic [31:0] ext_rdata;

    assign state_o   = state_q;
    assign req_size  = op_size(req_op_i);
    assign last_beat = ({1'b0, beat_q} == (beats_q - 3'd1));

    // Natural alignment of the incoming request.
    always_comb begin
        req_aligned = 1'b1;
        if (req_size == 3'd4)      req_aligned = (req_addr_i[1:0] == 2'b00);
        else if (req_size == 3'd2) req_aligned = (req_addr_i[0] == 1'b0);
    end

    lsu_load_extend u_ext (
        .op_i     (op_q),
        .data_i   (asm_q),
        .result_o (ext_rdata)
    );

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= `MEM_LB;
            addr_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
            beats_q <= 3'd1;
            beat_q  <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            asm_q   <= asm_d;
            beats_q <= beats_d;
            beat_q  <= beat_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    // Next-state: accept in IDLE, step beats and assemble load bytes in ISSUE.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        asm_d   = asm_q;
        beats_d = beats_q;
        beat_d  = beat_q;
        mis_d   = mis_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    asm_d   = '0;
                    beat_d  = '0;
                    mis_d   = !req_aligned;
                    beats_d = req_aligned ? 3'd1 : req_size;
                    if (!req_aligned && !ALLOW_MISALIGNED) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!op_is_store(op_q)) begin
                    if (mis_q) asm_d[{beat_q, 3'b000} +: 8] = mem_rdata_i[7:0];
                    else       asm_d = mem_rdata_i;
                end
                if (last_beat) begin
                    state_d = ST_DONE;
                    beat_d  = '0;
                end else begin
                    beat_d  = beat_q + 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state; idle cycles drive a non-writing LB at 0.
    always_comb begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_err_o   = 1'b0;
        rsp_rdata_o = '0;
        mem_fn_o    = `MEM_LB;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            ST_IDLE: req_ready_o = 1'b1;
            ST_ISSUE: begin
                if (!mis_q) begin
                    mem_fn_o    = op_q;
                    mem_addr_o  = addr_q;
                    mem_wdata_o = wdata_q;
                end else begin
                    mem_fn_o    = op_is_store(op_q) ? `MEM_SB : `MEM_LBU;
                    mem_addr_o  = addr_q + {30'h0, beat_q};
                    mem_wdata_o = {24'h0, wdata_q[{beat_q, 3'b000} +: 8]};
                end
            end
            ST_DONE: begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = err_q;
                rsp_rdata_o = err_q ? 32'h0 : ext_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: byte-addressed memory model, reference model
// of beats/results, directed scenarios and randomized traffic.
module tb_lsu_mem_initiator;
    import lsu_mem_initiator_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT A: misaligned accesses allowed
    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_err;
    logic [2:0]  a_req_op, a_mem_fn;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    lsu_state_e  a_state;

    // DUT B: misaligned accesses rejected
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_err;
    logic [2:0]  b_req_op, b_mem_fn;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    lsu_state_e  b_state;
    assign b_mem_rdata = 32'h0;

    lsu_mem_initiator #(.ALLOW_MISALIGNED(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_op_i(a_req_op),
        .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata),
        .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err),
        .mem_fn_o(a_mem_fn), .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata),
        .mem_rdata_i(a_mem_rdata), .state_o(a_state)
    );

    lsu_mem_initiator #(.ALLOW_MISALIGNED(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_op_i(b_req_op),
        .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
        .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err),
        .mem_fn_o(b_mem_fn), .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
        .mem_rdata_i(b_mem_rdata), .state_o(b_state)
    );

    int vectors = 0;
    int miscompares = 0;

    // ---------------- memory environment (for DUT A) ----------------
    logic [7:0] env_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];
    int         wr_cnt = 0;
    logic [2:0]  s_fn = `MEM_LB;
    logic [31:0] s_addr = '0, s_wdata = '0;
    logic [7:0]  mr0, mr1, mr2, mr3;
    int          b_store_seen = 0;

    function automatic logic [7:0] env_rd(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        env_mem[a] = d;
        ref_mem[a] = d;
    endtask

    // Combinational read, already extended by the memory
    always @(a_mem_fn or a_mem_addr or wr_cnt) begin
        mr0 = env_rd(a_mem_addr);
        mr1 = env_rd(a_mem_addr + 32'd1);
        mr2 = env_rd(a_mem_addr + 32'd2);
        mr3 = env_rd(a_mem_addr + 32'd3);
        case (a_mem_fn)
            `MEM_LB:  a_mem_rdata = {{24{mr0[7]}}, mr0};
            `MEM_LBU: a_mem_rdata = {24'h0, mr0};
            `MEM_LH:  a_mem_rdata = {{16{mr1[7]}}, mr1, mr0};
            `MEM_LHU: a_mem_rdata = {16'h0, mr1, mr0};
            `MEM_LW:  a_mem_rdata = {mr3, mr2, mr1, mr0};
            default:  a_mem_rdata = 32'h0;
        endcase
    end

    // Write port: command sampled mid-cycle, committed at the rising edge
    always @(negedge clk) begin
        s_fn = a_mem_fn;
        s_addr = a_mem_addr;
        s_wdata = a_mem_wdata;
        if (b_mem_fn == `MEM_SB || b_mem_fn == `MEM_SH || b_mem_fn == `MEM_SW)
            b_store_seen++;
    end

    always @(posedge clk) begin
        case (s_fn)
            `MEM_SB: begin env_mem[s_addr] = s_wdata[7:0]; wr_cnt++; end
            `MEM_SH: begin
                env_mem[s_addr] = s_wdata[7:0];
                env_mem[s_addr + 32'd1] = s_wdata[15:8];
                wr_cnt++;
            end
            `MEM_SW: begin
                env_mem[s_addr] = s_wdata[7:0];
                env_mem[s_addr + 32'd1] = s_wdata[15:8];
                env_mem[s_addr + 32'd2] = s_wdata[23:16];
                env_mem[s_addr + 32'd3] = s_wdata[31:24];
                wr_cnt++;
            end
            default: ;
        endcase
    end

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] op);
        if (op == `MEM_LW || op == `MEM_SW) return 4;
        if (op == `MEM_LH || op == `MEM_LHU || op == `MEM_SH) return 2;
        return 1;
    endfunction

    function automatic logic m_store(input logic [2:0] op);
        return (op == `MEM_SB) || (op == `MEM_SH) || (op == `MEM_SW);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] addr);
        logic [31:0] raw = 32'h0;
        for (int k = 0; k < m_size(op); k++)
            raw = raw + ({24'h0, ref_rd(addr + 32'(k))} << (8 * k));
        case (op)
            `MEM_LB: return (raw >= 32'd128)   ? raw - 32'd256   : raw;
            `MEM_LH: return (raw >= 32'd32768) ? raw - 32'd65536 : raw;
            default: return raw;
        endcase
    endfunction

    // ---------------- driver / checker for DUT A ----------------
    task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        int          size, nb, cyc;
        logic        mis, st;
        logic [31:0] exp_rd;
        logic [2:0]  exp_fn [4];
        logic [31:0] exp_ad [4];
        logic [31:0] exp_wd [4];
        logic [2:0]  o_fn [8];
        logic [31:0] o_ad [8];
        logic [31:0] o_wd [8];
        size = m_size(op);
        st   = m_store(op);
        mis  = (addr % 32'(size)) != 0;
        nb   = mis ? size : 1;
        for (int k = 0; k < nb; k++) begin
            exp_fn[k] = mis ? (st ? `MEM_SB : `MEM_LBU) : op;
            exp_ad[k] = mis ? addr + 32'(k) : addr;
            exp_wd[k] = mis ? ((wdata >> (8 * k)) & 32'hFF) : wdata;
        end
        exp_rd = st ? 32'h0 : m_load(op, addr);
        if (st) for (int k = 0; k < size; k++) ref_mem[addr + 32'(k)] = 8'((wdata >> (8 * k)) & 32'hFF);

        @(negedge clk);
        a_req_valid = 1'b1; a_req_op = op; a_req_addr = addr; a_req_wdata = wdata;
        vectors++;
        if (a_req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL req_ready_idle: got %b want 1", a_req_ready);
        end
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            if (a_rsp_valid === 1'b1) break;
            if (cyc < 8) begin o_fn[cyc] = a_mem_fn; o_ad[cyc] = a_mem_addr; o_wd[cyc] = a_mem_wdata; end
            cyc++;
        end
        vectors++;
        if (cyc >= 20) begin
            miscompares++;
            $display("FAIL rsp_timeout: op %0d addr %h no rsp_valid within 20 cycles", op, addr);
            return;
        end
        if (cyc != nb) begin
            miscompares++;
            $display("FAIL latency: op %0d addr %h got %0d beat cycles want %0d", op, addr, cyc, nb);
        end
        for (int k = 0; k < nb && k < cyc; k++) begin
            vectors++;
            if (o_fn[k] !== exp_fn[k] || o_ad[k] !== exp_ad[k] ||
                (st && mis && o_wd[k][7:0] !== exp_wd[k][7:0]) || (st && !mis && o_wd[k] !== exp_wd[k])) begin
                miscompares++;
                $display("FAIL beat%0d: got fn %0d addr %h wdata %h want fn %0d addr %h wdata %h",
                         k, o_fn[k], o_ad[k], o_wd[k], exp_fn[k], exp_ad[k], exp_wd[k]);
            end
        end
        vectors++;
        if (a_rsp_rdata !== exp_rd || a_rsp_err !== 1'b0 || a_req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rsp: op %0d addr %h got rdata %h err %b ready %b want rdata %h err 0 ready 0",
                     op, addr, a_rsp_rdata, a_rsp_err, a_req_ready, exp_rd);
        end
        vectors++;
        if (a_mem_fn !== `MEM_LB || a_mem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL idle_port: got fn %0d addr %h want fn 0 addr 0", a_mem_fn, a_mem_addr);
        end
    endtask

    task automatic check_env(input string name, input logic [31:0] a, input logic [7:0] want);
        vectors++;
        if (env_rd(a) !== want) begin
            miscompares++;
            $display("FAIL %s: mem[%h] got %h want %h", name, a, env_rd(a), want);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        @(negedge clk);
        vectors++;
        if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_rsp_err !== 1'b0 || a_rsp_rdata !== 32'h0 ||
            a_mem_fn !== `MEM_LB || a_mem_addr !== 32'h0 || a_mem_wdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_values: ready %b valid %b err %b rdata %h fn %0d addr %h wdata %h want 1 0 0 0 0 0 0",
                     a_req_ready, a_rsp_valid, a_rsp_err, a_rsp_rdata, a_mem_fn, a_mem_addr, a_mem_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: ready a %b b %b valid %b want 1 1 0", a_req_ready, b_req_ready, a_rsp_valid);
        end
    endtask

    task automatic test_aligned_lw;
        preload(32'h100, 8'hBB); preload(32'h101, 8'hAA); preload(32'h102, 8'h99); preload(32'h103, 8'h88);
        do_op(`MEM_LW, 32'h100, 32'h0);
        vectors++;
        if (a_rsp_rdata !== 32'h8899AABB) begin
            miscompares++;
            $display("FAIL aligned_lw: got %h want 8899aabb", a_rsp_rdata);
        end
    endtask

    task automatic test_misaligned_sw;
        do_op(`MEM_SW, 32'h201, 32'h11223344);
        check_env("sw_byte0", 32'h201, 8'h44);
        check_env("sw_byte1", 32'h202, 8'h33);
        check_env("sw_byte2", 32'h203, 8'h22);
        check_env("sw_byte3", 32'h204, 8'h11);
        for (int k = 1; k <= 4; k++) do_op(`MEM_LBU, 32'h200 + 32'(k), 32'h0);
        do_op(`MEM_LW, 32'h201, 32'h0);
        vectors++;
        if (a_rsp_rdata !== 32'h11223344) begin
            miscompares++;
            $display("FAIL sw_readback: got %h want 11223344", a_rsp_rdata);
        end
    endtask

    task automatic test_misaligned_lh;
        preload(32'h303, 8'h34); preload(32'h304, 8'hF2);
        do_op(`MEM_LH, 32'h303, 32'h0);
        vectors++;
        if (a_rsp_rdata !== 32'hFFFFF234) begin
            miscompares++;
            $display("FAIL lh_signed: got %h want fffff234", a_rsp_rdata);
        end
        do_op(`MEM_LHU, 32'h303, 32'h0);
        vectors++;
        if (a_rsp_rdata !== 32'h0000F234) begin
            miscompares++;
            $display("FAIL lhu_zero: got %h want 0000f234", a_rsp_rdata);
        end
    endtask

    task automatic test_wrap;
        do_op(`MEM_SW, 32'hFFFFFFFE, 32'hCAFEF00D);
        check_env("wrap_fffffffe", 32'hFFFFFFFE, 8'h0D);
        check_env("wrap_ffffffff", 32'hFFFFFFFF, 8'hF0);
        check_env("wrap_0", 32'h0, 8'hFE);
        check_env("wrap_1", 32'h1, 8'hCA);
    endtask

    task automatic test_no_misaligned;
        int cyc;
        b_store_seen = 0;
        @(negedge clk);
        b_req_valid = 1'b1; b_req_op = `MEM_SH; b_req_addr = 32'h401; b_req_wdata = 32'hBEEF;
        @(posedge clk);
        #1 b_req_valid = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            if (b_rsp_valid === 1'b1) break;
            cyc++;
        end
        vectors++;
        if (cyc != 0 || b_rsp_err !== 1'b1 || b_rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reject_sh: got wait %0d err %b rdata %h want wait 0 err 1 rdata 0", cyc, b_rsp_err, b_rsp_rdata);
        end
        @(negedge clk);
        vectors++;
        if (b_store_seen != 0 || b_rsp_valid !== 1'b0 || b_req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reject_quiet: got stores %0d valid %b ready %b want 0 0 1", b_store_seen, b_rsp_valid, b_req_ready);
        end
        // An aligned store still goes through on the rejecting variant
        b_req_valid = 1'b1; b_req_op = `MEM_SW; b_req_addr = 32'h400; b_req_wdata = 32'h12345678;
        @(posedge clk);
        #1 b_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (b_store_seen != 1) begin
            miscompares++;
            $display("FAIL reject_aligned_ok: got %0d store cycles want 1", b_store_seen);
        end
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 5; k++) preload(32'h600 + 32'(k), 8'hA0 + 8'(k));
        @(negedge clk);
        a_req_valid = 1'b1; a_req_op = `MEM_SW; a_req_addr = 32'h601; a_req_wdata = 32'hDDCCBBAA;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        vectors++;
        if (a_mem_fn !== `MEM_SB || a_mem_addr !== 32'h603) begin
            miscompares++;
            $display("FAIL mid_beat2: got fn %0d addr %h want fn 5 addr 603", a_mem_fn, a_mem_addr);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_mem_fn !== `MEM_LB ||
            a_mem_addr !== 32'h0 || a_mem_wdata !== 32'h0 || a_rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset: ready %b valid %b fn %0d addr %h wdata %h rdata %h want 1 0 0 0 0 0",
                     a_req_ready, a_rsp_valid, a_mem_fn, a_mem_addr, a_mem_wdata, a_rsp_rdata);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_mem[32'h601] = 8'hAA;
        ref_mem[32'h602] = 8'hBB;
        @(negedge clk);
        vectors++;
        if (a_req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset: got %b want 1", a_req_ready);
        end
        check_env("kept_beat0", 32'h601, 8'hAA);
        check_env("kept_beat1", 32'h602, 8'hBB);
        check_env("dropped_beat2", 32'h603, 8'hA3);
        check_env("dropped_beat3", 32'h604, 8'hA4);
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [31:0] addr;
        for (int k = 0; k < 32; k++) preload(32'h500 + 32'(k), 8'($urandom));
        for (int n = 0; n < 40; n++) begin
            op   = 3'($urandom_range(0, 7));
            addr = 32'h500 + 32'($urandom_range(0, 27));
            do_op(op, addr, $urandom);
        end
        for (int k = 0; k < 32; k++) begin
            vectors++;
            if (env_rd(32'h500 + 32'(k)) !== ref_rd(32'h500 + 32'(k))) begin
                miscompares++;
                $display("FAIL random_mem: mem[%h] got %h want %h", 32'h500 + 32'(k),
                         env_rd(32'h500 + 32'(k)), ref_rd(32'h500 + 32'(k)));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_req_valid = 1'b0; a_req_op = `MEM_LB; a_req_addr = '0; a_req_wdata = '0;
        b_req_valid = 1'b0; b_req_op = `MEM_LB; b_req_addr = '0; b_req_wdata = '0;
        repeat (3) @(posedge clk);
        test_reset();
        test_aligned_lw();
        test_misaligned_sw();
        test_misaligned_lh();
        test_wrap();
        test_no_misaligned();
        test_random();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
